xor_par_chk: RTL and testbench
==============================

XOR_PAR_CHK -- requirements
Module: xor_par_chk

Interface
REQ-001 SHALL have parameter WIDTH, default 30: data and parity word width in bits.
REQ-002 SHALL have parameter FRAME_WORDS, default 8: words per frame, equal to FRAME_WORDS-1 data words plus 1 parity word; legal range 2..256.
REQ-003 SHALL have parameter CNT_WIDTH, default 16: width of the error counter.
REQ-004 SHALL have parameter LOCK_FRAMES, default 4: consecutive clean frames needed to assert lock; legal range 1..15.
REQ-005 SHALL have parameter TARGET_CHIP, default 2: passed unchanged to the XOR primitives.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port arst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port din_valid, input, 1 bit: din and sof are qualified this cycle.
REQ-009 SHALL have port din, input, WIDTH bits: received word.
REQ-010 SHALL have port sof, input, 1 bit: din is the first data word of a frame.
REQ-011 SHALL have port force_err, input, 1 bit: test injection; inverts syndrome bit 0 of the frame whose parity word is accepted this cycle.
REQ-012 SHALL have port clr_cnt, input, 1 bit: synchronous clear of err_cnt.
REQ-013 SHALL have port dout_valid, output, 1 bit: one-cycle pulse per completed frame.
REQ-014 SHALL have port syndrome, output, WIDTH bits: XOR of all data words and the parity word.
REQ-015 SHALL have port frame_err, output, 1 bit: syndrome is nonzero; valid with dout_valid.
REQ-016 SHALL have port misalign, output, 1 bit: one-cycle pulse on a framing violation.
REQ-017 SHALL have port lock, output, 1 bit: frame alignment is trusted.
REQ-018 SHALL have port err_cnt, output, CNT_WIDTH bits: saturating count of errored frames.

Function
REQ-019 SHALL act as the receive-side check for column parity, where the parity word equals the bitwise XOR of the FRAME_WORDS-1 data words.
REQ-020 SHALL implement states HUNT and RUN, with a word counter wcnt of ceil(log2(FRAME_WORDS)) bits.
REQ-021 SHALL ignore all inputs except clr_cnt when din_valid is 0; gaps of any length are legal and SHALL NOT change state, accumulator or wcnt.
REQ-022 In HUNT, a valid word with sof=1 SHALL load acc<=din and wcnt<=1 and move to RUN.
REQ-023 In HUNT, a valid word with sof=0 SHALL be discarded and SHALL NOT raise misalign.
REQ-024 In RUN with 0<wcnt<FRAME_WORDS-1 and sof=0, the block SHALL update acc<=acc^din and wcnt<=wcnt+1.
REQ-025 In RUN with wcnt=FRAME_WORDS-1 (parity word), the block SHALL register syndrome<=acc^din, with bit 0 additionally inverted if force_err=1.
REQ-026 On a parity word, the block SHALL assert dout_valid in the next cycle, set frame_err=|syndrome in the same cycle, and set wcnt<=0.
REQ-027 In RUN with wcnt=0, a valid word with sof=1 SHALL start a new frame as in REQ-022.
REQ-028 In RUN with wcnt=0, a valid word with sof=0 SHALL pulse misalign and move to HUNT.
REQ-029 In RUN with wcnt>0, a valid word with sof=1 SHALL pulse misalign, abandon the partial frame with no dout_valid and no err_cnt change, and restart the frame with that word (acc<=din, wcnt<=1).
REQ-030 misalign SHALL be registered and appear in the cycle after the offending word.
REQ-031 The parity-word XOR SHALL be at most 2 LUT levels deep, built from xor_lut leaves, with dout_valid latency exactly 1 cycle.
REQ-032 lock SHALL rise in the same cycle as the dout_valid of the LOCK_FRAMES-th consecutive frame with frame_err=0.
REQ-033 An errored frame SHALL reset the clean-frame run without dropping lock.
REQ-034 A misalign pulse SHALL clear lock and the clean-frame run in the same cycle.
REQ-035 err_cnt SHALL increment on each dout_valid with frame_err=1 and saturate at all-ones.
REQ-036 When clr_cnt and an increment occur in the same cycle, err_cnt SHALL become 1.
REQ-037 syndrome and frame_err SHALL hold their last values between dout_valid pulses.

Reset
REQ-038 Asserting arst_n=0 at any time, including mid-frame, SHALL immediately force state=HUNT, wcnt=0, acc=0, syndrome=0, frame_err=0, dout_valid=0, misalign=0, lock=0, err_cnt=0, clean-run=0.
REQ-039 The first word accepted after reset is released SHALL be treated per REQ-022/REQ-023.

Verification (WIDTH=30, FRAME_WORDS=4, LOCK_FRAMES=4, CNT_WIDTH=2)
REQ-040 Reset mid-frame -> all outputs 0 immediately; the next sof word starts a fresh frame.
REQ-041 sof+0x1, 0x2, 0x4, then parity 0x7 -> dout_valid 1 cycle after the parity word, syndrome=0, frame_err=0, err_cnt=0; the same result holds with idle gaps inserted.
REQ-042 Same data with parity 0x6 -> syndrome=0x1, frame_err=1, err_cnt=1; a clean frame with force_err=1 -> syndrome=0x1.
REQ-043 sof, word, then sof after 2 words -> misalign pulse; the restarted frame completes normally; err_cnt unchanged.
REQ-044 4 clean frames -> lock=1 on the 4th dout_valid; then a non-sof word at wcnt=0 -> misalign=1, lock=0, state HUNT.
REQ-045 4 bad frames -> err_cnt saturates at 3; clr_cnt together with a 5th bad frame -> err_cnt=1.

Source files
------------

// File: rtl/xor_par_chk.sv
// Receive-side column-parity checker.
// A frame is FRAME_WORDS-1 data words followed by one parity word equal to the
// XOR of the data words. The block tracks frame alignment from sof and reports
// the XOR syndrome of each completed frame. It keeps a clean-frame lock
// indicator and a saturating errored-frame counter.
// err_cnt and lock update on the same edge that raises dout_valid, so a clr_cnt
// presented with the parity word of an errored frame yields err_cnt=1.

// Single-bit three-input XOR leaf; the build target only selects the grouping.
module xor_lut #(
  parameter int TARGET_CHIP = 2
) (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);
  if (TARGET_CHIP == 1) begin : g_pair
    assign y = (a ^ b) ^ c;
  end else begin : g_flat
    assign y = a ^ b ^ c;
  end
endmodule

module xor_par_chk #(
  parameter int WIDTH       = 30,
  parameter int FRAME_WORDS = 8,
  parameter int CNT_WIDTH   = 16,
  parameter int LOCK_FRAMES = 4,
  parameter int TARGET_CHIP = 2
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 din_valid,
  input  logic [WIDTH-1:0]     din,
  input  logic                 sof,
  input  logic                 force_err,
  input  logic                 clr_cnt,
  output logic                 dout_valid,
  output logic [WIDTH-1:0]     syndrome,
  output logic                 frame_err,
  output logic                 misalign,
  output logic                 lock,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  localparam int WCNT_W = (FRAME_WORDS > 2) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(FRAME_WORDS - 1);
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic [WIDTH-1:0]  acc, acc_nxt;
  logic              vld_p0;
  logic              misalign_nxt;
  logic [WIDTH-1:0]  inv_mask;
  logic [WIDTH-1:0]  syn_p0;
  logic              err_p0;
  logic [3:0]        clean_run;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [3:0] run_inc(input logic [3:0] v);
    return (v >= LOCK_N) ? v : v + 4'd1;
  endfunction

  // ---- stage p0: parity-word syndrome, one XOR leaf per bit ----
  assign inv_mask = WIDTH'(force_err);

  for (genvar i = 0; i < WIDTH; i++) begin : g_syn
    xor_lut #(.TARGET_CHIP(TARGET_CHIP)) u_leaf (
      .a(acc[i]),
      .b(din[i]),
      .c(inv_mask[i]),
      .y(syn_p0[i])
    );
  end

  assign err_p0 = |syn_p0;

  // Framing FSM: next state, word count, accumulator and event strobes.
  always_comb begin
    state_nxt    = state;
    wcnt_nxt     = wcnt;
    acc_nxt      = acc;
    vld_p0       = 1'b0;
    misalign_nxt = 1'b0;
    if (din_valid) begin
      case (state)
        HUNT: begin
          if (sof) begin
            acc_nxt   = din;
            wcnt_nxt  = WCNT_W'(1);
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (wcnt == '0) begin
            if (sof) begin
              acc_nxt  = din;
              wcnt_nxt = WCNT_W'(1);
            end else begin
              misalign_nxt = 1'b1;
              wcnt_nxt     = '0;
              state_nxt    = HUNT;
            end
          end else if (sof) begin
            // Early sof: drop the partial frame and restart on this word.
            misalign_nxt = 1'b1;
            acc_nxt      = din;
            wcnt_nxt     = WCNT_W'(1);
          end else if (wcnt == LAST_WORD) begin
            vld_p0   = 1'b1;
            wcnt_nxt = '0;
          end else begin
            acc_nxt  = acc ^ din;
            wcnt_nxt = wcnt + 1'b1;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Framing state register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= HUNT;
      wcnt  <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      acc   <= acc_nxt;
    end
  end

  // ---- stage p1: registered frame result; syndrome holds between frames ----
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      dout_valid <= 1'b0;
      syndrome   <= '0;
      frame_err  <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      dout_valid <= vld_p0;
      misalign   <= misalign_nxt;
      if (vld_p0) begin
        syndrome  <= syn_p0;
        frame_err <= err_p0;
      end
    end
  end

  // Lock tracking: clean frames build the run, misalignment tears it down.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      lock      <= 1'b0;
      clean_run <= '0;
    end else if (misalign_nxt) begin
      lock      <= 1'b0;
      clean_run <= '0;
    end else if (vld_p0) begin
      if (err_p0) begin
        clean_run <= '0;
      end else begin
        clean_run <= run_inc(clean_run);
        if (run_inc(clean_run) >= LOCK_N) begin
          lock <= 1'b1;
        end
      end
    end
  end

  // Errored-frame counter; a coincident clear leaves just the new error counted.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      err_cnt <= '0;
    end else if (vld_p0 && err_p0) begin
      err_cnt <= clr_cnt ? CNT_WIDTH'(1) : sat_inc(err_cnt);
    end else if (clr_cnt) begin
      err_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_xor_par_chk.sv
// Bench for xor_par_chk at WIDTH=30, FRAME_WORDS=4, LOCK_FRAMES=4, CNT_WIDTH=2.
// Directed vector table, a reset-mid-frame sequence, then random traffic
// compared against a frame-level reference model.
module tb_xor_par_chk;

  localparam int W    = 30;
  localparam int FW   = 4;
  localparam int LF   = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          din_valid;
  logic [W-1:0]  din;
  logic          sof;
  logic          force_err;
  logic          clr_cnt;
  logic          dout_valid;
  logic [W-1:0]  syndrome;
  logic          frame_err;
  logic          misalign;
  logic          lock;
  logic [CW-1:0] err_cnt;

  xor_par_chk #(
    .WIDTH(W), .FRAME_WORDS(FW), .CNT_WIDTH(CW), .LOCK_FRAMES(LF), .TARGET_CHIP(2)
  ) dut (
    .clk(clk), .arst_n(arst_n), .din_valid(din_valid), .din(din), .sof(sof),
    .force_err(force_err), .clr_cnt(clr_cnt), .dout_valid(dout_valid),
    .syndrome(syndrome), .frame_err(frame_err), .misalign(misalign),
    .lock(lock), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic         v, s;
    logic [W-1:0] d;
    logic         f, c;
    logic         dv;
    logic [W-1:0] syn;
    logic         ferr, mis, lk;
    logic [1:0]   cnt;
  } vec_t;

  vec_t tab[$];

  // Reference model: a frame is the list of words since sof.
  logic         m_hunt;
  logic [W-1:0] m_words[$];
  logic         m_dv, m_mis, m_ferr, m_lock;
  logic [W-1:0] m_syn;
  int           m_clean, m_cnt;

  task automatic model_reset();
    m_hunt = 1'b1; m_words.delete();
    m_dv = 0; m_mis = 0; m_ferr = 0; m_lock = 0; m_syn = '0;
    m_clean = 0; m_cnt = 0;
  endtask

  task automatic model_step(input logic v, s, input logic [W-1:0] d, input logic f, c);
    logic [W-1:0] x;
    m_dv = 0; m_mis = 0;
    if (v) begin
      if (m_hunt) begin
        if (s) begin m_words.delete(); m_words.push_back(d); m_hunt = 0; end
      end else if (s) begin
        if (m_words.size() != 0) m_mis = 1;
        m_words.delete(); m_words.push_back(d);
      end else if (m_words.size() == 0) begin
        m_mis = 1; m_hunt = 1;
      end else begin
        m_words.push_back(d);
        if (m_words.size() == FW) begin
          x = '0;
          foreach (m_words[k]) x ^= m_words[k];
          if (f) x[0] = ~x[0];
          m_syn = x; m_ferr = (x != '0); m_dv = 1;
          m_words.delete();
        end
      end
    end
    if (m_mis) begin m_lock = 0; m_clean = 0; end
    if (m_dv) begin
      if (m_ferr) m_clean = 0;
      else begin m_clean++; if (m_clean >= LF) m_lock = 1; end
    end
    if (m_dv && m_ferr) m_cnt = c ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
    else if (c) m_cnt = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic dv, input logic [W-1:0] syn,
                           input logic ferr, mis, lk, input logic [1:0] cnt);
    chk({tag, " dout_valid"}, 32'(dout_valid), 32'(dv));
    chk({tag, " syndrome"},   32'(syndrome),   32'(syn));
    chk({tag, " frame_err"},  32'(frame_err),  32'(ferr));
    chk({tag, " misalign"},   32'(misalign),   32'(mis));
    chk({tag, " lock"},       32'(lock),       32'(lk));
    chk({tag, " err_cnt"},    32'(err_cnt),    32'(cnt));
  endtask

  // Drive one cycle on the falling edge, sample just after the rising edge.
  task automatic apply(input logic v, s, input logic [W-1:0] d, input logic f, c);
    @(negedge clk);
    din_valid = v; sof = s; din = d; force_err = f; clr_cnt = c;
    @(posedge clk);
    #1;
    model_step(v, s, d, f, c);
  endtask

  task automatic add(input int v, s, input logic [W-1:0] d, input int f, c, dv,
                     input logic [W-1:0] syn, input int ferr, mis, lk, cnt);
    vec_t r;
    r.v = (v != 0); r.s = (s != 0); r.d = d; r.f = (f != 0); r.c = (c != 0);
    r.dv = (dv != 0); r.syn = syn; r.ferr = (ferr != 0); r.mis = (mis != 0);
    r.lk = (lk != 0); r.cnt = 2'(cnt);
    tab.push_back(r);
  endtask

  initial begin
    logic         v, s, f, c;
    logic [W-1:0] d, gen_acc;
    int           gen_pos;

    // ---- vector table ----
    // clean frame 1,2,4 / 7
    add(1,1,30'h1,0,0, 0,30'h0,0,0,0,0);
    add(1,0,30'h2,0,0, 0,30'h0,0,0,0,0);
    add(1,0,30'h4,0,0, 0,30'h0,0,0,0,0);
    add(1,0,30'h7,0,0, 1,30'h0,0,0,0,0);
    // same frame with idle gaps carrying junk
    add(1,1,30'h1,0,0, 0,30'h0,0,0,0,0);
    add(0,1,30'h3FF,1,0, 0,30'h0,0,0,0,0);
    add(1,0,30'h2,0,0, 0,30'h0,0,0,0,0);
    add(0,1,30'h12345,0,0, 0,30'h0,0,0,0,0);
    add(0,0,30'h0,0,0, 0,30'h0,0,0,0,0);
    add(1,0,30'h4,0,0, 0,30'h0,0,0,0,0);
    add(1,0,30'h7,0,0, 1,30'h0,0,0,0,0);
    // bad parity 6
    add(1,1,30'h1,0,0, 0,30'h0,0,0,0,0);
    add(1,0,30'h2,0,0, 0,30'h0,0,0,0,0);
    add(1,0,30'h4,0,0, 0,30'h0,0,0,0,0);
    add(1,0,30'h6,0,0, 1,30'h1,1,0,0,1);
    add(0,0,30'h0,0,0, 0,30'h1,1,0,0,1);
    // clean frame with injected error
    add(1,1,30'h1,0,0, 0,30'h1,1,0,0,1);
    add(1,0,30'h2,0,0, 0,30'h1,1,0,0,1);
    add(1,0,30'h4,0,0, 0,30'h1,1,0,0,1);
    add(1,0,30'h7,1,0, 1,30'h1,1,0,0,2);
    // early sof after two words, restarted frame completes clean
    add(1,1,30'h8,0,0, 0,30'h1,1,0,0,2);
    add(1,0,30'h9,0,0, 0,30'h1,1,0,0,2);
    add(1,1,30'h1,0,0, 0,30'h1,1,1,0,2);
    add(1,0,30'h2,0,0, 0,30'h1,1,0,0,2);
    add(1,0,30'h4,0,0, 0,30'h1,1,0,0,2);
    add(1,0,30'h7,0,0, 1,30'h0,0,0,0,2);
    // three more clean frames -> lock on the fourth clean dout_valid
    add(1,1,30'h3FFFFFFF,0,0, 0,30'h0,0,0,0,2);
    add(1,0,30'h15555555,0,0, 0,30'h0,0,0,0,2);
    add(1,0,30'h2AAAAAAA,0,0, 0,30'h0,0,0,0,2);
    add(1,0,30'h0,0,0,        1,30'h0,0,0,0,2);
    add(1,1,30'h0000ABCD,0,0, 0,30'h0,0,0,0,2);
    add(1,0,30'h12340000,0,0, 0,30'h0,0,0,0,2);
    add(1,0,30'h00000001,0,0, 0,30'h0,0,0,0,2);
    add(1,0,30'h1234ABCC,0,0, 1,30'h0,0,0,0,2);
    add(1,1,30'h1,0,0, 0,30'h0,0,0,0,2);
    add(1,0,30'h2,0,0, 0,30'h0,0,0,0,2);
    add(1,0,30'h4,0,0, 0,30'h0,0,0,0,2);
    add(1,0,30'h7,0,0, 1,30'h0,0,0,1,2);
    // non-sof at frame boundary -> misalign, lock drops, HUNT discards next
    add(1,0,30'h5,0,0, 0,30'h0,0,1,0,2);
    add(1,0,30'h5,0,0, 0,30'h0,0,0,0,2);
    // clear, then four bad frames saturate the counter
    add(0,0,30'h0,0,1, 0,30'h0,0,0,0,0);
    for (int k = 0; k < 4; k++) begin
      add(1,1,30'h1,0,0, 0,(k == 0) ? 30'h0 : 30'h1,(k != 0),0,0,(k < 3) ? k : 3);
      add(1,0,30'h2,0,0, 0,(k == 0) ? 30'h0 : 30'h1,(k != 0),0,0,(k < 3) ? k : 3);
      add(1,0,30'h4,0,0, 0,(k == 0) ? 30'h0 : 30'h1,(k != 0),0,0,(k < 3) ? k : 3);
      add(1,0,30'h6,0,0, 1,30'h1,1,0,0,(k + 1 < 3) ? k + 1 : 3);
    end
    // fifth bad frame with clear on its parity word
    add(1,1,30'h1,0,0, 0,30'h1,1,0,0,3);
    add(1,0,30'h2,0,0, 0,30'h1,1,0,0,3);
    add(1,0,30'h4,0,0, 0,30'h1,1,0,0,3);
    add(1,0,30'h6,0,1, 1,30'h1,1,0,0,1);

    // ---- reset state ----
    arst_n = 1'b0; din_valid = 0; sof = 0; din = '0; force_err = 0; clr_cnt = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_all("reset", 0, '0, 0, 0, 0, 2'd0);
    arst_n = 1'b1;

    // ---- table ----
    foreach (tab[i]) begin
      apply(tab[i].v, tab[i].s, tab[i].d, tab[i].f, tab[i].c);
      check_all($sformatf("tab%0d", i), tab[i].dv, tab[i].syn, tab[i].ferr,
                tab[i].mis, tab[i].lk, tab[i].cnt);
    end

    // ---- asynchronous reset in the middle of a frame ----
    apply(1, 1, 30'h1, 0, 0);
    apply(1, 0, 30'h2, 0, 0);
    check_all("pre_rst", 0, 30'h1, 1, 0, 0, 2'd1);
    #2 arst_n = 1'b0;
    #1 check_all("mid_rst", 0, '0, 0, 0, 0, 2'd0);
    model_reset();
    @(negedge clk); @(negedge clk);
    arst_n = 1'b1;
    apply(1, 0, 30'h4, 0, 0);
    check_all("rst_nonsof", 0, '0, 0, 0, 0, 2'd0);
    apply(1, 1, 30'h1, 0, 0);
    apply(1, 0, 30'h2, 0, 0);
    apply(1, 0, 30'h4, 0, 0);
    check_all("rst_frame_mid", 0, '0, 0, 0, 0, 2'd0);
    apply(1, 0, 30'h7, 0, 0);
    check_all("rst_frame_end", 1, '0, 0, 0, 0, 2'd0);

    // ---- random traffic against the model ----
    gen_pos = 0; gen_acc = '0;
    for (int i = 0; i < 2000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 19) == 0);
      c = ($urandom_range(0, 29) == 0);
      d = W'($urandom);
      s = ($urandom_range(0, 1) != 0);
      if (v) begin
        s = (gen_pos == 0);
        if ($urandom_range(0, 24) == 0) s = ~s;
        if (!s && gen_pos == FW - 1 && $urandom_range(0, 3) != 0) d = gen_acc;
        if (s) begin
          gen_acc = d; gen_pos = 1;
        end else if (gen_pos == FW - 1) begin
          gen_pos = 0;
        end else if (gen_pos != 0) begin
          gen_acc ^= d; gen_pos++;
        end
      end
      apply(v, s, d, f, c);
      check_all($sformatf("rnd%0d", i), m_dv, m_syn, m_ferr, m_mis, m_lock, 2'(m_cnt));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
